// File: rtl/ffbank_clrset_seq.sv
// ffbank_clrset_seq
// Sequences the asynchronous clear/set pins of a D flip-flop bank. One
// operation drives clr_n or set_n low for ASSERT_CYC cycles, then holds
// clk_en low for RECOV_CYC more cycles so that no capturing edge falls
// inside the flops' recovery window. Requests are latched as pending flags
// and set has priority over clear. Reset is treated as a clear operation.
module ffbank_clrset_seq #(
    parameter int ASSERT_CYC = 4,
    parameter int RECOV_CYC  = 2,
    parameter int CNT_W      = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_req,
    input  logic set_req,
    output logic clr_n,
    output logic set_n,
    output logic clk_en,
    output logic busy,
    output logic done,
    output logic op_set
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] ASSERT_LOAD = CNT_W'(ASSERT_CYC - 1);
    localparam logic [CNT_W-1:0] RECOV_LOAD  = CNT_W'(RECOV_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pend_clr_q;
    logic             pend_set_q;
    logic             clr_n_q;
    logic             set_n_q;
    logic             clk_en_q;
    logic             busy_q;
    logic             done_q;
    logic             op_set_q;

    // Pending view including this cycle's request, so a request seen in
    // IDLE launches on the very next edge and one seen while busy is kept.
    logic pend_clr_d;
    logic pend_set_d;

    assign pend_clr_d = pend_clr_q | clr_req;
    assign pend_set_d = pend_set_q | set_req;

    // Sequencer FSM: state, shared down-counter, pending flags, and all
    // bank-facing outputs registered so the async pins never glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_ASSERT;
            cnt_q      <= ASSERT_LOAD;
            pend_clr_q <= 1'b0;
            pend_set_q <= 1'b0;
            clr_n_q    <= 1'b0;
            set_n_q    <= 1'b1;
            clk_en_q   <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            op_set_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pend_set_d) begin
                        // Set wins, matching the flop's set-override priority.
                        state_q    <= ST_ASSERT;
                        cnt_q      <= ASSERT_LOAD;
                        pend_set_q <= 1'b0;
                        pend_clr_q <= pend_clr_d;
                        clr_n_q    <= 1'b1;
                        set_n_q    <= 1'b0;
                        clk_en_q   <= 1'b0;
                        busy_q     <= 1'b1;
                        op_set_q   <= 1'b1;
                    end else if (pend_clr_d) begin
                        state_q    <= ST_ASSERT;
                        cnt_q      <= ASSERT_LOAD;
                        pend_set_q <= 1'b0;
                        pend_clr_q <= 1'b0;
                        clr_n_q    <= 1'b0;
                        set_n_q    <= 1'b1;
                        clk_en_q   <= 1'b0;
                        busy_q     <= 1'b1;
                        op_set_q   <= 1'b0;
                    end else begin
                        state_q    <= ST_IDLE;
                        pend_set_q <= 1'b0;
                        pend_clr_q <= 1'b0;
                        clr_n_q    <= 1'b1;
                        set_n_q    <= 1'b1;
                        clk_en_q   <= 1'b1;
                        busy_q     <= 1'b0;
                    end
                end
                ST_ASSERT: begin
                    pend_set_q <= pend_set_d;
                    pend_clr_q <= pend_clr_d;
                    clk_en_q   <= 1'b0;
                    busy_q     <= 1'b1;
                    if (cnt_q == CNT_ZERO) begin
                        state_q <= ST_RECOVER;
                        cnt_q   <= RECOV_LOAD;
                        clr_n_q <= 1'b1;
                        set_n_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                ST_RECOVER: begin
                    pend_set_q <= pend_set_d;
                    pend_clr_q <= pend_clr_d;
                    clr_n_q    <= 1'b1;
                    set_n_q    <= 1'b1;
                    if (cnt_q == CNT_ZERO) begin
                        state_q  <= ST_IDLE;
                        clk_en_q <= 1'b1;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end else begin
                        cnt_q    <= cnt_q - CNT_ONE;
                        clk_en_q <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                default: begin
                    // Unreachable encoding: restart as a clear, like reset.
                    state_q    <= ST_ASSERT;
                    cnt_q      <= ASSERT_LOAD;
                    pend_clr_q <= 1'b0;
                    pend_set_q <= 1'b0;
                    clr_n_q    <= 1'b0;
                    set_n_q    <= 1'b1;
                    clk_en_q   <= 1'b0;
                    busy_q     <= 1'b1;
                    op_set_q   <= 1'b0;
                end
            endcase
        end
    end

    assign clr_n  = clr_n_q;
    assign set_n  = set_n_q;
    assign clk_en = clk_en_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign op_set = op_set_q;

endmodule

// File: tb/tb_ffbank_clrset_seq.sv
// Bench for ffbank_clrset_seq: two instances (default timing and 1/1 timing)
// driven by the same stimulus, compared every cycle against an
// operation-age model, plus hand-computed literal expectations.
module tb_ffbank_clrset_seq;

    localparam int LOGN = 16384;
    localparam int B_CLR = 5, B_SET = 4, B_EN = 3, B_BUSY = 2, B_DONE = 1, B_OPS = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr_req = 1'b0;
    logic set_req = 1'b0;

    logic clr_n0, set_n0, clk_en0, busy0, done0, op_set0;
    logic clr_n1, set_n1, clk_en1, busy1, done1, op_set1;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;

    logic s_rst = 1'b0, s_clr = 1'b0, s_set = 1'b0, s_valid = 1'b0;

    // Output log per instance, indexed by cycle: {clr_n,set_n,clk_en,busy,done,op_set}
    logic [5:0] lg [2][LOGN];

    // Model state per instance
    int   m_a   [2] = '{4, 1};
    int   m_r   [2] = '{2, 1};
    logic m_act [2] = '{1'b0, 1'b0};
    logic m_type[2] = '{1'b0, 1'b0};
    int   m_age [2] = '{0, 0};
    logic m_pc  [2] = '{1'b0, 1'b0};
    logic m_ps  [2] = '{1'b0, 1'b0};
    logic m_done[2] = '{1'b0, 1'b0};

    ffbank_clrset_seq u_dut0 (
        .clk(clk), .rst(rst), .clr_req(clr_req), .set_req(set_req),
        .clr_n(clr_n0), .set_n(set_n0), .clk_en(clk_en0),
        .busy(busy0), .done(done0), .op_set(op_set0)
    );

    ffbank_clrset_seq #(.ASSERT_CYC(1), .RECOV_CYC(1), .CNT_W(4)) u_dut1 (
        .clk(clk), .rst(rst), .clr_req(clr_req), .set_req(set_req),
        .clr_n(clr_n1), .set_n(set_n1), .clk_en(clk_en1),
        .busy(busy1), .done(done1), .op_set(op_set1)
    );

    always #5 clk = ~clk;

    // Capture the inputs the DUTs sampled at this edge, and count cycles.
    always @(posedge clk) begin
        cyc_n   <= cyc_n + 1;
        s_rst   <= rst;
        s_clr   <= clr_req;
        s_set   <= set_req;
        s_valid <= 1'b1;
    end

    // Model: an operation is "age" cycles old; the line is low for ages
    // 1..A, clk_en low for ages 1..A+R, and age A+R+1 is the done cycle.
    task automatic model_step(input int k);
        logic nset, nclr;
        nset = m_ps[k] | s_set;
        nclr = m_pc[k] | s_clr;
        m_done[k] = 1'b0;
        if (s_rst) begin
            m_act[k] = 1'b1; m_type[k] = 1'b0; m_age[k] = 1;
            m_ps[k] = 1'b0; m_pc[k] = 1'b0;
        end else if (m_act[k]) begin
            m_age[k] = m_age[k] + 1;
            if (m_age[k] > m_a[k] + m_r[k]) begin
                m_act[k] = 1'b0; m_done[k] = 1'b1;
            end
            m_ps[k] = nset; m_pc[k] = nclr;
        end else if (nset) begin
            m_act[k] = 1'b1; m_type[k] = 1'b1; m_age[k] = 1;
            m_ps[k] = 1'b0; m_pc[k] = nclr;
        end else if (nclr) begin
            m_act[k] = 1'b1; m_type[k] = 1'b0; m_age[k] = 1;
            m_ps[k] = 1'b0; m_pc[k] = 1'b0;
        end else begin
            m_ps[k] = 1'b0; m_pc[k] = 1'b0;
        end
    endtask

    function automatic logic [5:0] model_out(input int k);
        logic low;
        low = m_act[k] && (m_age[k] <= m_a[k]);
        if (m_act[k])
            return {~(low & ~m_type[k]), ~(low & m_type[k]), 1'b0, 1'b1, 1'b0, m_type[k]};
        else
            return {1'b1, 1'b1, 1'b1, 1'b0, m_done[k], m_type[k]};
    endfunction

    // Per-cycle compare and invariant check on the falling edge.
    always @(negedge clk) begin
        logic [5:0] act [2];
        logic [5:0] exp_v;
        act[0] = {clr_n0, set_n0, clk_en0, busy0, done0, op_set0};
        act[1] = {clr_n1, set_n1, clk_en1, busy1, done1, op_set1};
        if (s_valid) begin
            for (int k = 0; k < 2; k++) begin
                model_step(k);
                exp_v = model_out(k);
                checks++;
                if (act[k] !== exp_v) begin
                    errors++;
                    $display("FAIL model dut%0d cycle %0d: got %b expected %b", k, cyc_n, act[k], exp_v);
                end
                checks++;
                if (!(act[k][B_CLR] | act[k][B_SET])) begin
                    errors++;
                    $display("FAIL both_low dut%0d cycle %0d: clr_n=0 set_n=0 expected not both 0", k, cyc_n);
                end
                checks++;
                if ((!act[k][B_CLR] || !act[k][B_SET]) && act[k][B_EN] !== 1'b0) begin
                    errors++;
                    $display("FAIL en_while_low dut%0d cycle %0d: clk_en=%b expected 0", k, cyc_n, act[k][B_EN]);
                end
                if (cyc_n < LOGN) lg[k][cyc_n] = act[k];
            end
        end
    end

    task automatic drv(input logic r, input logic c, input logic s, output int t);
        @(posedge clk);
        #1;
        rst = r; clr_req = c; set_req = s;
        t = cyc_n;
    endtask

    task automatic idle(input int n);
        int t;
        for (int i = 0; i < n; i++) drv(1'b0, 1'b0, 1'b0, t);
    endtask

    task automatic lit(input string nm, input int k, input int c, input int b, input logic e);
        checks++;
        if (lg[k][c][b] !== e) begin
            errors++;
            $display("FAIL %s: dut%0d cycle %0d got %b expected %b", nm, k, c, lg[k][c][b], e);
        end
    endtask

    initial begin
        int t, tr, ts, tb2, tm, tx, ndone;

        // Reset held three cycles, then released
        drv(1'b1, 1'b0, 1'b0, t);
        drv(1'b1, 1'b0, 1'b0, t);
        drv(1'b1, 1'b0, 1'b0, tr);
        idle(12);

        // Single set
        drv(1'b0, 1'b0, 1'b1, ts);
        idle(12);

        // Simultaneous clear and set
        drv(1'b0, 1'b1, 1'b1, tb2);
        idle(18);

        // Request merge: clear, then three more clear requests during ASSERT
        drv(1'b0, 1'b1, 1'b0, tm);
        drv(1'b0, 1'b1, 1'b0, t);
        drv(1'b0, 1'b1, 1'b0, t);
        drv(1'b0, 1'b1, 1'b0, t);
        idle(26);

        // Reset in the middle of a set; a set request alongside rst is dropped
        drv(1'b0, 1'b0, 1'b1, tx);
        drv(1'b0, 1'b0, 1'b0, t);
        drv(1'b1, 1'b0, 1'b1, t);
        idle(26);

        // Literal expectations
        lit("rst_busy", 0, tr, B_BUSY, 1'b1);
        lit("rst_clr_first", 0, tr + 1, B_CLR, 1'b0);
        lit("rst_clr_last", 0, tr + 4, B_CLR, 1'b0);
        lit("rst_clr_rel", 0, tr + 5, B_CLR, 1'b1);
        lit("rst_en_recov", 0, tr + 6, B_EN, 1'b0);
        lit("rst_done", 0, tr + 7, B_DONE, 1'b1);
        lit("rst_en_back", 0, tr + 7, B_EN, 1'b1);
        lit("rst_busy_idle", 0, tr + 7, B_BUSY, 1'b0);

        lit("set_low_first", 0, ts + 1, B_SET, 1'b0);
        lit("set_low_last", 0, ts + 4, B_SET, 1'b0);
        lit("set_released", 0, ts + 5, B_SET, 1'b1);
        lit("set_en_recov", 0, ts + 6, B_EN, 1'b0);
        lit("set_done", 0, ts + 7, B_DONE, 1'b1);
        lit("set_op", 0, ts + 7, B_OPS, 1'b1);
        for (int c = ts; c <= ts + 7; c++) lit("set_clr_high", 0, c, B_CLR, 1'b1);

        lit("both_set_done", 0, tb2 + 7, B_DONE, 1'b1);
        lit("both_set_op", 0, tb2 + 7, B_OPS, 1'b1);
        lit("both_gap_en", 0, tb2 + 7, B_EN, 1'b1);
        lit("both_gap_en_pre", 0, tb2 + 6, B_EN, 1'b0);
        lit("both_gap_en_post", 0, tb2 + 8, B_EN, 1'b0);
        lit("both_clr_first", 0, tb2 + 8, B_CLR, 1'b0);
        lit("both_clr_last", 0, tb2 + 11, B_CLR, 1'b0);
        lit("both_clr_rel", 0, tb2 + 12, B_CLR, 1'b1);
        lit("both_clr_nodone", 0, tb2 + 13, B_DONE, 1'b0);
        lit("both_clr_done", 0, tb2 + 14, B_DONE, 1'b1);
        lit("both_clr_op", 0, tb2 + 14, B_OPS, 1'b0);

        ndone = 0;
        for (int c = tm + 1; c <= tm + 26; c++) ndone += int'(lg[0][c][B_DONE]);
        checks++;
        if (ndone != 2) begin
            errors++;
            $display("FAIL merge_done_count: got %0d expected 2", ndone);
        end
        lit("merge_second_done", 0, tm + 14, B_DONE, 1'b1);
        lit("merge_idle", 0, tm + 15, B_BUSY, 1'b0);

        lit("abort_set_low", 0, tx + 2, B_SET, 1'b0);
        lit("abort_set_rel", 0, tx + 3, B_SET, 1'b1);
        lit("abort_clr_low", 0, tx + 3, B_CLR, 1'b0);
        for (int c = tx + 1; c <= tx + 8; c++) lit("abort_no_done", 0, c, B_DONE, 1'b0);
        lit("abort_rst_done", 0, tx + 9, B_DONE, 1'b1);
        lit("abort_rst_op", 0, tx + 9, B_OPS, 1'b0);
        for (int c = tx + 3; c <= tx + 26; c++) lit("abort_no_replay", 0, c, B_SET, 1'b1);

        lit("fast_set_low", 1, ts + 1, B_SET, 1'b0);
        lit("fast_set_rel", 1, ts + 2, B_SET, 1'b1);
        lit("fast_en_recov", 1, ts + 2, B_EN, 1'b0);
        lit("fast_done", 1, ts + 3, B_DONE, 1'b1);
        lit("fast_en_back", 1, ts + 3, B_EN, 1'b1);

        // Random phase: sparse resets, frequent requests
        for (int i = 0; i < 10000; i++) begin
            drv(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 7) == 0), t);
        end
        idle(12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
